// File: rtl/uart_pkg.sv
// Shared UART definitions: gray-coded FSM states and parity-sense constants,
// used by both the transmitter and the receiver.
package uart_pkg;

  // Adjacent states differ in one bit along the normal frame path.
  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_START  = 3'b001;
  localparam logic [2:0] ST_DATA   = 3'b011;
  localparam logic [2:0] ST_PARITY = 3'b010;
  localparam logic [2:0] ST_STOP   = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: pulses bit_end on the last clock of each CLKS_PER_BIT-clock
// bit period. restart aligns a fresh period to the next clock.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // A restart cycle belongs to no bit, so it never ends one.
  assign bit_end = en && !restart && (cnt == '0);

  // Down-counter reloads at zero; never wraps past its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (restart) cnt <= RELOAD;
    else if (en)      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W bits LSB-first, optional
// parity, 1 or 2 stop bits, one word per valid/ready handshake.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              tx_clk,
  input  logic              reset_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx
);

  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_W - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic           PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_tx_param: PARITY_EN/PARITY_ODD must be 0 or 1");
  end

  uart_state_e       state;
  logic [DATA_W-1:0] shift_reg;
  logic [BCW-1:0]    bit_cnt;
  logic              stop_cnt;
  logic              parity;
  logic              accept;
  logic              bit_end;

  assign accept = (state == IDLE) && tx_valid && tx_ready;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (tx_clk),
    .rst_n   (reset_n),
    .restart (accept),
    .en      (state != IDLE),
    .bit_end (bit_end)
  );

  // Frame sequencer; every output is registered so tx is glitch-free.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      parity    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= tx_data;
            parity    <= (^tx_data) ^ PAR_SENSE;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            state     <= START;
            tx        <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four frame formats side by side, each frame
// compared cycle by cycle against a waveform built from the frame rules.
module tb_uart_tx_param;

  // Per-instance configuration: 8N1/4, 8E1/4, 8O1/3, 7N2/1
  localparam int DW  [4] = '{8, 8, 8, 7};
  localparam int PE  [4] = '{0, 1, 1, 0};
  localparam int PO  [4] = '{0, 0, 1, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};
  localparam int CPB [4] = '{4, 4, 3, 1};

  logic       tx_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] vld = '0;
  logic [8:0] data [4];
  logic [3:0] tx_o, rdy, bsy, dn;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tx_clk = ~tx_clk;

  uart_tx_param #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_8n1 (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_valid(vld[0]), .tx_data(data[0][7:0]),
    .tx_ready(rdy[0]), .tx_busy(bsy[0]), .tx_done(dn[0]), .tx(tx_o[0]));
  uart_tx_param #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_8e1 (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_valid(vld[1]), .tx_data(data[1][7:0]),
    .tx_ready(rdy[1]), .tx_busy(bsy[1]), .tx_done(dn[1]), .tx(tx_o[1]));
  uart_tx_param #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .CLKS_PER_BIT(3)) u_8o1 (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_valid(vld[2]), .tx_data(data[2][7:0]),
    .tx_ready(rdy[2]), .tx_busy(bsy[2]), .tx_done(dn[2]), .tx(tx_o[2]));
  uart_tx_param #(.DATA_W(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .CLKS_PER_BIT(1)) u_7n2 (
    .tx_clk(tx_clk), .reset_n(reset_n), .tx_valid(vld[3]), .tx_data(data[3][6:0]),
    .tx_ready(rdy[3]), .tx_busy(bsy[3]), .tx_done(dn[3]), .tx(tx_o[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected line level for each cycle after acceptance (bit k = cycle k+1).
  function automatic logic [63:0] exp_wave(input int idx, input logic [8:0] w);
    logic [63:0] v;
    int   k, ones, nb;
    logic b;
    v    = '1;
    k    = 0;
    ones = 0;
    for (int i = 0; i < DW[idx]; i++) ones += int'(w[i]);
    nb = 1 + DW[idx] + PE[idx] + SB[idx];
    for (int s = 0; s < nb; s++) begin
      if (s == 0)                             b = 1'b0;
      else if (s <= DW[idx])                  b = w[s-1];
      else if (PE[idx] == 1 && s == DW[idx]+1) b = 1'((ones % 2) ^ PO[idx]);
      else                                    b = 1'b1;
      for (int c = 0; c < CPB[idx]; c++) begin
        v[k] = b;
        k++;
      end
    end
    return v;
  endfunction

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    @(negedge tx_clk);
    while (!rdy[idx] && n < 200) begin
      @(negedge tx_clk);
      n++;
    end
    chk($sformatf("d%0d_ready_wait", idx), 64'(rdy[idx]), 64'd1);
  endtask

  // One frame: offer (unless already offered), then record every cycle up to
  // the tx_done cycle. keep holds tx_valid with nxt for a back-to-back word;
  // pulse offers a stray word mid-frame that must be ignored.
  task automatic frame(input int idx, input logic [8:0] w_in, input bit pre,
                       input bit keep, input logic [8:0] nxt, input bit pulse);
    logic [63:0] ot, ob, orr, od, mask;
    logic [8:0]  w;
    int len;
    len  = CPB[idx] * (1 + DW[idx] + PE[idx] + SB[idx]);
    w    = w_in & 9'((1 << DW[idx]) - 1);
    mask = (64'd1 << len) - 64'd1;
    if (!pre) begin
      wait_ready(idx);
      vld[idx]  = 1'b1;
      data[idx] = w;
    end
    @(posedge tx_clk);
    #1;
    if (keep) data[idx] = nxt;
    else begin
      vld[idx]  = 1'b0;
      data[idx] = 9'($urandom);
    end
    ot = '1; ob = '0; orr = '0; od = '0;
    for (int k = 0; k < len; k++) begin
      @(negedge tx_clk);
      ot[k]  = tx_o[idx];
      ob[k]  = bsy[idx];
      orr[k] = rdy[idx];
      od[k]  = dn[idx];
      if (pulse && k == len/2) begin
        vld[idx]  = 1'b1;
        data[idx] = ~w;
      end
      if (pulse && k == len/2 + 1) vld[idx] = 1'b0;
    end
    chk($sformatf("d%0d_w%0h_tx", idx, w), ot, exp_wave(idx, w));
    chk($sformatf("d%0d_w%0h_busy", idx, w), ob, mask);
    chk($sformatf("d%0d_w%0h_ready", idx, w), orr, 64'd0);
    chk($sformatf("d%0d_w%0h_done_early", idx, w), od, 64'd0);
    @(negedge tx_clk);
    chk($sformatf("d%0d_w%0h_done", idx, w), {tx_o[idx], rdy[idx], bsy[idx], dn[idx]}, 64'b1101);
    if (pulse) begin
      @(negedge tx_clk);
      chk($sformatf("d%0d_no_extra", idx), {tx_o[idx], bsy[idx]}, 64'b10);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data[i] = '0;
    repeat (2) @(negedge tx_clk);
    chk("rst_tx",    64'(tx_o), 64'hF);
    chk("rst_ready", 64'(rdy),  64'hF);
    chk("rst_busy",  64'(bsy),  64'h0);
    chk("rst_done",  64'(dn),   64'h0);
    reset_n = 1'b1;

    // Directed frames from the test plan
    frame(0, 9'h0A5, 1'b0, 1'b0, 9'h0, 1'b0);
    frame(1, 9'h0A5, 1'b0, 1'b0, 9'h0, 1'b0);
    frame(2, 9'h0A5, 1'b0, 1'b0, 9'h0, 1'b0);
    frame(1, 9'h001, 1'b0, 1'b0, 9'h0, 1'b0);
    frame(3, 9'h07F, 1'b0, 1'b0, 9'h0, 1'b0);

    // Back-to-back: valid held, second start right after tx_done
    frame(0, 9'h055, 1'b0, 1'b1, 9'h00F, 1'b0);
    frame(0, 9'h00F, 1'b1, 1'b0, 9'h0,   1'b0);
    frame(3, 9'h02A, 1'b0, 1'b1, 9'h055, 1'b0);
    frame(3, 9'h055, 1'b1, 1'b0, 9'h0,   1'b0);

    // Stray valid and data change mid-frame
    frame(1, 9'h0C3, 1'b0, 1'b0, 9'h0, 1'b1);

    // Randomized frames on every format
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++)
        frame(i, 9'($urandom), 1'b0, 1'b0, 9'h0, ($urandom_range(0, 3) == 0));

    // Reset in the middle of DATA bit 3 (cycles 17..20 after acceptance)
    wait_ready(0);
    vld[0]  = 1'b1;
    data[0] = 9'h0C3;
    @(posedge tx_clk);
    #1 vld[0] = 1'b0;
    repeat (18) @(negedge tx_clk);
    chk("mid_busy", 64'(bsy[0]), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", {tx_o[0], rdy[0], bsy[0], dn[0]}, 64'b1100);
    @(negedge tx_clk);
    reset_n = 1'b1;
    frame(0, 9'h03C, 1'b0, 1'b0, 9'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
